// File: rtl/alu_wb_pkg.sv
// Shared types for the ALU writeback stage: default widths, queue entry, flag bundle.
// No logic; widths here must match the alu_writeback parameters used.
// No flow control.
package alu_wb_pkg;

   localparam int WB_DW   = 32;
   localparam int WB_NREG = 8;
   localparam int WB_AW   = 3;

   // One pending ALU result waiting to be committed
   typedef struct packed {
      logic [WB_AW-1:0] rd;
      logic [WB_DW-1:0] res;
      logic             z;
      logic             c;
      logic             v;
      logic             wen;
   } wb_entry_t;

   typedef struct packed {
      logic z;
      logic c;
      logic v;
   } flags_t;

   // Occupancy summary kept by the queue controller
   typedef enum logic [1:0] {
      Q_EMPTY   = 2'd0,
      Q_PARTIAL = 2'd1,
      Q_FULL    = 2'd2
   } q_state_e;

endpackage

// File: rtl/wb_queue.sv
// DEPTH-entry FIFO of wb_entry_t; all live entries exposed in age order for forwarding.
// Latency: entry readable at head the cycle after enqueue.
// Backpressure: caller must not enq when full unless deq in the same cycle.
module wb_queue
   import alu_wb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            enq,
   input  wb_entry_t       enq_entry,
   input  logic            deq,
   output wb_entry_t       head,
   output logic [CW-1:0]   count,
   output logic            empty,
   output logic            full,
   output wb_entry_t       age_entry [DEPTH],
   output logic [DEPTH-1:0] age_vld
);

   wb_entry_t      mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   q_state_e       state;

   // Storage is not reset: only entries below count are ever observed
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= enq_entry;
   end

   // Controller: pointers wrap naturally (DEPTH is a power of two), count tracks occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= Q_EMPTY;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10: begin
               count <= count + 1'b1;
               state <= (count == CW'(DEPTH - 1)) ? Q_FULL : Q_PARTIAL;
            end
            2'b01: begin
               count <= count - 1'b1;
               state <= (count == CW'(1)) ? Q_EMPTY : Q_PARTIAL;
            end
            default: ;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (state == Q_EMPTY);
   assign full  = (state == Q_FULL);

   // Present entries oldest-first (index 0 = head) so consumers can pick the youngest match
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age_entry[i] = mem[rd_ptr + PW'(i)];
         age_vld[i]   = (CW'(i) < count);
      end
   end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: queues results, commits head into regfile+flags, forwards youngest queued write to reads.
// Latency: 1 cycle accept-to-commit when queue empty and hold=0; reads are combinational.
// Backpressure: in_ready drops only when queue full and no commit this cycle. Option macro: ALU_WB_STICKY_V_EN.
module alu_writeback
   import alu_wb_pkg::*;
#(
   parameter int DW    = WB_DW,
   parameter int NREG  = WB_NREG,
   parameter int AW    = WB_AW,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_rd,
   input  logic [DW-1:0] in_res,
   input  logic          in_z,
   input  logic          in_c,
   input  logic          in_v,
   input  logic          in_wen,
   input  logic          hold,
   input  logic [AW-1:0] ra_addr,
   output logic [DW-1:0] ra_data,
   input  logic [AW-1:0] rb_addr,
   output logic [DW-1:0] rb_data,
   output logic          flag_z,
   output logic          flag_c,
   output logic          flag_v,
`ifdef ALU_WB_STICKY_V_EN
   input  logic          clr_v,
`endif
   output logic [AW:0]   q_count
);

   localparam int CW = $clog2(DEPTH + 1);

   wb_entry_t        enq_entry;
   wb_entry_t        head;
   wb_entry_t        age_entry [DEPTH];
   logic [DEPTH-1:0] age_vld;
   logic [CW-1:0]    count;
   logic             q_empty;
   logic             q_full;
   logic             commit;
   logic             accept;
   logic [DW-1:0]    regs [NREG];
   flags_t           flags;

   assign commit   = !q_empty && !hold;
   assign in_ready = !q_full || commit;
   assign accept   = in_valid && in_ready;

   assign enq_entry = '{rd: in_rd, res: in_res, z: in_z, c: in_c, v: in_v, wen: in_wen};

   wb_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .enq       (accept),
      .enq_entry (enq_entry),
      .deq       (commit),
      .head      (head),
      .count     (count),
      .empty     (q_empty),
      .full      (q_full),
      .age_entry (age_entry),
      .age_vld   (age_vld)
   );

   assign q_count = (AW + 1)'(count);

   // Register file: head entry writes its destination only when wen is set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (commit && head.wen) begin
         regs[head.rd] <= head.res;
      end
   end

   // Flags load from every committed entry, wen or not
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= '0;
      end else begin
         if (commit) begin
            flags.z <= head.z;
            flags.c <= head.c;
         end
`ifdef ALU_WB_STICKY_V_EN
         // Sticky overflow: a committing v=1 beats a same-cycle clear
         if (commit && head.v) flags.v <= 1'b1;
         else if (clr_v)       flags.v <= 1'b0;
`else
         if (commit) flags.v <= head.v;
`endif
      end
   end

   assign flag_z = flags.z;
   assign flag_c = flags.c;
   assign flag_v = flags.v;

   // Read ports: scan oldest to youngest so the youngest matching queued write wins over the regfile
   always_comb begin
      ra_data = regs[ra_addr];
      rb_data = regs[rb_addr];
      for (int i = 0; i < DEPTH; i++) begin
         if (age_vld[i] && age_entry[i].wen && age_entry[i].rd == ra_addr) ra_data = age_entry[i].res;
         if (age_vld[i] && age_entry[i].wen && age_entry[i].rd == rb_addr) rb_data = age_entry[i].res;
      end
   end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus randomized traffic against a queue-based model.
// Inputs change after the falling edge; outputs are compared 1 ns later, well clear of the rising edge.
// Build with ALU_WB_STICKY_V_EN to exercise the sticky overflow flag and clr_v.
module tb_alu_writeback;

   typedef struct {
      logic [2:0]  rd;
      logic [31:0] res;
      logic        z;
      logic        c;
      logic        v;
      logic        wen;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_rd;
   logic [31:0] in_res;
   logic        in_z, in_c, in_v, in_wen;
   logic        hold;
   logic [2:0]  ra_addr, rb_addr;
   logic [31:0] ra_data, rb_data;
   logic        flag_z, flag_c, flag_v;
   logic        clr_v;
   logic [3:0]  q_count;

   int tests = 0;
   int fails = 0;

   // Reference model state
   ent_t        mq[$];
   logic [31:0] mregs [8];
   logic        mz, mc, mv;
   logic        m_last_acc;

   always #5 clk = ~clk;

   alu_writeback dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_rd    (in_rd),
      .in_res   (in_res),
      .in_z     (in_z),
      .in_c     (in_c),
      .in_v     (in_v),
      .in_wen   (in_wen),
      .hold     (hold),
      .ra_addr  (ra_addr),
      .ra_data  (ra_data),
      .rb_addr  (rb_addr),
      .rb_data  (rb_data),
      .flag_z   (flag_z),
      .flag_c   (flag_c),
      .flag_v   (flag_v),
`ifdef ALU_WB_STICKY_V_EN
      .clr_v    (clr_v),
`endif
      .q_count  (q_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      mq.delete();
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      mz = 1'b0; mc = 1'b0; mv = 1'b0;
      m_last_acc = 1'b1;
   endtask

   function automatic logic [31:0] m_read(input logic [2:0] a);
      logic [31:0] r;
      r = mregs[a];
      foreach (mq[i]) if (mq[i].wen && mq[i].rd == a) r = mq[i].res;
      return r;
   endfunction

   function automatic logic m_ready();
      return (mq.size() < 2) || (mq.size() > 0 && !hold);
   endfunction

   // Advance the model by one rising edge using the inputs presented this cycle
   task automatic m_update();
      logic do_commit, do_acc;
      ent_t e;
      if (!rst_n) begin
         m_reset();
         return;
      end
      do_commit = (mq.size() > 0) && !hold;
      do_acc    = in_valid && m_ready();
      if (do_commit) begin
         e = mq.pop_front();
         mz = e.z;
         mc = e.c;
`ifdef ALU_WB_STICKY_V_EN
         if (e.v) mv = 1'b1;
         else if (clr_v) mv = 1'b0;
`else
         mv = e.v;
`endif
         if (e.wen) mregs[e.rd] = e.res;
      end
`ifdef ALU_WB_STICKY_V_EN
      else if (clr_v) mv = 1'b0;
`endif
      if (do_acc) mq.push_back('{rd: in_rd, res: in_res, z: in_z, c: in_c, v: in_v, wen: in_wen});
      m_last_acc = do_acc;
   endtask

   task automatic check_model();
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready()});
      chk("q_count",  {28'b0, q_count},  mq.size());
      chk("ra_data",  ra_data, m_read(ra_addr));
      chk("rb_data",  rb_data, m_read(rb_addr));
      chk("flag_z",   {31'b0, flag_z}, {31'b0, mz});
      chk("flag_c",   {31'b0, flag_c}, {31'b0, mc});
      chk("flag_v",   {31'b0, flag_v}, {31'b0, mv});
   endtask

   task automatic drive(input logic v, input logic [2:0] rd, input logic [31:0] res,
                        input logic z, input logic c, input logic vv, input logic wen,
                        input logic h, input logic [2:0] a, input logic [2:0] b);
      in_valid = v;   in_rd = rd;   in_res = res;
      in_z = z;       in_c = c;     in_v = vv;     in_wen = wen;
      hold = h;       ra_addr = a;  rb_addr = b;
   endtask

   task automatic idle(input logic h, input logic [2:0] a, input logic [2:0] b);
      drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, h, a, b);
   endtask

   task automatic settle();
      #1;
      check_model();
   endtask

   task automatic tick();
      @(posedge clk);
      m_update();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      clr_v = 1'b0;
      idle(1'b0, 3'd3, 3'd0);
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      settle();
      chk("rst_ra3", ra_data, 32'h0);
      chk("rst_flags", {29'b0, flag_z, flag_c, flag_v}, 32'h0);
      chk("rst_ready", {31'b0, in_ready}, 32'h1);
      chk("rst_qcount", {28'b0, q_count}, 32'h0);

      // Single accept, forwarded then committed
      drive(1'b1, 3'd2, 32'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2);
      settle(); tick();
      idle(1'b0, 3'd0, 3'd2);
      settle();
      chk("fwd_rb2", rb_data, 32'h5);
      chk("fwd_qcount", {28'b0, q_count}, 32'h1);
      tick();
      idle(1'b0, 3'd0, 3'd2);
      settle();
      chk("commit_qcount", {28'b0, q_count}, 32'h0);
      chk("commit_rb2", rb_data, 32'h5);
      tick();

      // Hold: two writes to r1, youngest forwarded, then drained in order
      drive(1'b1, 3'd1, 32'hA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 3'd2);
      settle(); tick();
      drive(1'b1, 3'd1, 32'hB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 3'd2);
      settle(); tick();
      idle(1'b1, 3'd1, 3'd2);
      settle();
      chk("hold_ready", {31'b0, in_ready}, 32'h0);
      chk("hold_ra1", ra_data, 32'hB);
      chk("hold_qcount", {28'b0, q_count}, 32'h2);
      tick();
      idle(1'b1, 3'd1, 3'd2);
      settle();
      chk("hold_frozen", {28'b0, q_count}, 32'h2);
      tick();
      idle(1'b0, 3'd1, 3'd2);
      settle(); tick();
      idle(1'b0, 3'd1, 3'd2);
      settle(); tick();
      idle(1'b0, 3'd1, 3'd2);
      settle();
      chk("drain_ra1", ra_data, 32'hB);
      chk("drain_flags", {29'b0, flag_z, flag_c, flag_v}, 32'h2);
      chk("drain_qcount", {28'b0, q_count}, 32'h0);
      tick();

      // Full queue streaming: one in, one out per cycle
      drive(1'b1, 3'd3, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 3'd4);
      settle(); tick();
      drive(1'b1, 3'd4, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 3'd4);
      settle(); tick();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 3'(3 + k), 32'h100 + k, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 3'd6);
         settle();
         chk("stream_qcount", {28'b0, q_count}, 32'h2);
         chk("stream_ready", {31'b0, in_ready}, 32'h1);
         tick();
      end
      idle(1'b0, 3'd3, 3'd6);
      settle(); tick();
      idle(1'b0, 3'd3, 3'd6);
      settle(); tick();
      idle(1'b0, 3'd5, 3'd6);
      settle();
      chk("stream_r5", ra_data, 32'h102);
      chk("stream_r6", rb_data, 32'h103);
      tick();

      // Flags-only entry leaves the register file alone
      drive(1'b1, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2);
      settle(); tick();
      idle(1'b0, 3'd0, 3'd2);
      settle(); tick();
      idle(1'b0, 3'd0, 3'd2);
      settle();
      chk("flagonly_rb2", rb_data, 32'h5);
      chk("flagonly_c", {31'b0, flag_c}, 32'h1);
      chk("flagonly_v", {31'b0, flag_v}, 32'h1);
      tick();

      // Reset with two queued entries: nothing reaches the register file
      drive(1'b1, 3'd4, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 3'd5);
      settle(); tick();
      drive(1'b1, 3'd5, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 3'd5);
      settle(); tick();
      idle(1'b0, 3'd4, 3'd5);
      rst_n = 1'b0;
      m_reset();
      settle();
      chk("arst_qcount", {28'b0, q_count}, 32'h0);
      tick();
      rst_n = 1'b1;
      settle(); tick();
      idle(1'b0, 3'd4, 3'd5);
      settle();
      chk("arst_r4", ra_data, 32'h0);
      chk("arst_r5", rb_data, 32'h0);
      chk("arst_ready", {31'b0, in_ready}, 32'h1);
      tick();

`ifdef ALU_WB_STICKY_V_EN
      // Sticky overflow flag
      drive(1'b1, 3'd1, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
      settle(); tick();
      drive(1'b1, 3'd1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
      settle(); tick();
      idle(1'b0, 3'd0, 3'd0);
      settle(); tick();
      idle(1'b0, 3'd0, 3'd0);
      settle();
      chk("sticky_hold", {31'b0, flag_v}, 32'h1);
      clr_v = 1'b1;
      tick();
      clr_v = 1'b0;
      idle(1'b0, 3'd0, 3'd0);
      settle();
      chk("sticky_clr", {31'b0, flag_v}, 32'h0);
      drive(1'b1, 3'd1, 32'h3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
      settle(); tick();
      clr_v = 1'b1;
      idle(1'b0, 3'd0, 3'd0);
      settle(); tick();
      clr_v = 1'b0;
      settle();
      chk("sticky_wins", {31'b0, flag_v}, 32'h1);
      tick();
`endif

      // Randomized traffic; a refused payload is held stable until accepted
      m_last_acc = 1'b1;
      for (int n = 0; n < 600; n++) begin
         hold = ($urandom_range(0, 3) == 0);
         if (!(in_valid && !m_last_acc)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_rd    = 3'($urandom_range(0, 7));
            in_res   = $urandom;
            in_z     = 1'($urandom_range(0, 1));
            in_c     = 1'($urandom_range(0, 1));
            in_v     = 1'($urandom_range(0, 1));
            in_wen   = ($urandom_range(0, 3) != 0);
         end
         ra_addr = 3'($urandom_range(0, 7));
         rb_addr = 3'($urandom_range(0, 7));
`ifdef ALU_WB_STICKY_V_EN
         clr_v = ($urandom_range(0, 7) == 0);
`endif
         settle();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
